// File: rtl/hash_table_kv.sv
// rtl/hash_table_kv.sv - key/value hash table lookup engine with chaining or linear probing
module hash_table_kv #(
   parameter int    KEY_WIDTH        = 32,
   parameter int    VALUE_WIDTH      = 32,
   parameter int    TOTAL_INDEX      = 64,
   parameter int    CHAINING_SIZE    = 4,
   parameter string COLLISION_METHOD = "MULTI_STAGE_CHAINING",
   parameter string HASH_ALGORITHM   = "MODULUS",
   localparam int   INDEX_WIDTH      = $clog2(TOTAL_INDEX),
   localparam int   CHAIN_WIDTH      = (CHAINING_SIZE > 2) ? $clog2(CHAINING_SIZE) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [KEY_WIDTH-1:0]   key_in,
   input  logic [VALUE_WIDTH-1:0] value_in,
   input  logic [1:0]             op_sel,
   input  logic                   op_en,
   output logic [VALUE_WIDTH-1:0] value_out,
   output logic                   op_done,
   output logic                   op_error,
   output logic [CHAIN_WIDTH-1:0] collision_count
);

   localparam bit IS_LP      = (COLLISION_METHOD == "LINEAR_PROBING");
   localparam int NUM_SLOTS  = IS_LP ? TOTAL_INDEX : TOTAL_INDEX * CHAINING_SIZE;
   localparam int SLOT_WIDTH = $clog2(NUM_SLOTS);
   localparam int PTR_WIDTH  = ((INDEX_WIDTH > CHAIN_WIDTH) ? INDEX_WIDTH : CHAIN_WIDTH) + 1;
   localparam logic [PTR_WIDTH-1:0] LAST_PROBE = IS_LP ? PTR_WIDTH'(TOTAL_INDEX - 1)
                                                       : PTR_WIDTH'(CHAINING_SIZE - 1);

   localparam logic [1:0] OP_INSERT = 2'b00;
   localparam logic [1:0] OP_DELETE = 2'b01;
   localparam logic [1:0] OP_SEARCH = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_PROBE, ST_DONE} state_t;

   state_t state, state_nxt;

   // Slot storage: chain idx occupies slots idx*CHAINING_SIZE .. +CHAINING_SIZE-1;
   // in linear probing each index is exactly one slot.
   logic [NUM_SLOTS-1:0]   valid_bits;
   logic [NUM_SLOTS-1:0]   tomb_bits;
   logic [KEY_WIDTH-1:0]   key_mem [NUM_SLOTS];
   logic [VALUE_WIDTH-1:0] val_mem [NUM_SLOTS];

   // Latched operation and probe bookkeeping
   logic [KEY_WIDTH-1:0]   key_q;
   logic [VALUE_WIDTH-1:0] val_q;
   logic [1:0]             op_q;
   logic [INDEX_WIDTH-1:0] idx_q;
   logic [PTR_WIDTH-1:0]   ptr;
   logic                   match_found;
   logic [SLOT_WIDTH-1:0]  match_slot;
   logic                   free_found;
   logic [SLOT_WIDTH-1:0]  free_slot;

   logic [INDEX_WIDTH-1:0] hash_idx;
   logic [INDEX_WIDTH-1:0] lin_slot;
   logic [SLOT_WIDTH-1:0]  chain_slot;
   logic [SLOT_WIDTH-1:0]  cur_slot;
   logic                   slot_valid;
   logic                   slot_tomb;
   logic                   slot_hit;
   logic                   probe_end;
   logic                   done_error;

   // Only the modulus hash exists; every other selection falls back to it
   if (HASH_ALGORITHM == "MODULUS") begin : g_hash_mod
      assign hash_idx = key_in[INDEX_WIDTH-1:0];
   end else begin : g_hash_default
      assign hash_idx = key_in[INDEX_WIDTH-1:0];
   end

   // Address and classify the slot under the probe pointer
   always_comb begin
      lin_slot   = idx_q + ptr[INDEX_WIDTH-1:0];
      chain_slot = SLOT_WIDTH'(idx_q) * SLOT_WIDTH'(CHAINING_SIZE) + SLOT_WIDTH'(ptr);
      cur_slot   = IS_LP ? SLOT_WIDTH'(lin_slot) : chain_slot;
      slot_valid = valid_bits[cur_slot];
      slot_tomb  = tomb_bits[cur_slot];
      slot_hit   = slot_valid && (key_mem[cur_slot] == key_q);
      // A never-used entry ends a linear probe; tombstones keep it going
      probe_end  = slot_hit || (ptr == LAST_PROBE) || (IS_LP && !slot_valid && !slot_tomb);
   end

   // Outcome of the finished probe for the latched op
   always_comb begin
      done_error = 1'b1;
      case (op_q)
         OP_INSERT: done_error = !match_found && !free_found;
         OP_DELETE: done_error = !match_found;
         OP_SEARCH: done_error = !match_found;
         default:   done_error = 1'b1;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // FSM next state: reserved op skips the probe entirely
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (op_en) state_nxt = (op_sel == 2'b11) ? ST_DONE : ST_PROBE;
         ST_PROBE: if (probe_end) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Op capture, probe tracking and registered result outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_q           <= '0;
         val_q           <= '0;
         op_q            <= '0;
         idx_q           <= '0;
         ptr             <= '0;
         match_found     <= 1'b0;
         match_slot      <= '0;
         free_found      <= 1'b0;
         free_slot       <= '0;
         value_out       <= '0;
         op_done         <= 1'b0;
         op_error        <= 1'b0;
         collision_count <= '0;
      end else begin
         op_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (op_en) begin
                  key_q           <= key_in;
                  val_q           <= value_in;
                  op_q            <= op_sel;
                  idx_q           <= hash_idx;
                  ptr             <= '0;
                  match_found     <= 1'b0;
                  free_found      <= 1'b0;
                  collision_count <= '0;
               end
            end
            ST_PROBE: begin
               if (slot_valid && !slot_hit && (collision_count != '1))
                  collision_count <= collision_count + CHAIN_WIDTH'(1);
               if (slot_hit) begin
                  match_found <= 1'b1;
                  match_slot  <= cur_slot;
               end
               if (!slot_valid && !free_found) begin
                  free_found <= 1'b1;
                  free_slot  <= cur_slot;
               end
               ptr <= ptr + PTR_WIDTH'(1);
            end
            ST_DONE: begin
               op_done   <= 1'b1;
               op_error  <= done_error;
               value_out <= ((op_q == OP_SEARCH) && match_found) ? val_mem[match_slot] : '0;
            end
            default: ;
         endcase
      end
   end

   // Occupancy bits change only in DONE, so an aborted op leaves the table intact
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_bits <= '0;
         tomb_bits  <= '0;
      end else if (state == ST_DONE) begin
         if ((op_q == OP_INSERT) && !match_found && free_found) begin
            valid_bits[free_slot] <= 1'b1;
            tomb_bits[free_slot]  <= 1'b0;
         end
         if ((op_q == OP_DELETE) && match_found) begin
            valid_bits[match_slot] <= 1'b0;
            tomb_bits[match_slot]  <= IS_LP;
         end
      end
   end

   // Key/value payload, qualified by valid_bits so it needs no reset
   always_ff @(posedge clk) begin
      if ((state == ST_DONE) && (op_q == OP_INSERT)) begin
         if (match_found) begin
            val_mem[match_slot] <= val_q;
         end else if (free_found) begin
            key_mem[free_slot] <= key_q;
            val_mem[free_slot] <= val_q;
         end
      end
   end

endmodule

// File: tb/tb_hash_table_kv.sv
// tb/tb_hash_table_kv.sv - self-checking bench for hash_table_kv (chaining and linear probing)
module tb_hash_table_kv;

   localparam logic [1:0] OP_I = 2'd0;
   localparam logic [1:0] OP_D = 2'd1;
   localparam logic [1:0] OP_S = 2'd2;
   localparam logic [1:0] OP_R = 2'd3;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] k;
      logic [31:0] v;
      logic [31:0] ev;
      logic        ee;
      logic [1:0]  ec;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, rst_lp;
   logic        op_en, op_en_lp;
   logic [31:0] key_in, value_in;
   logic [1:0]  op_sel;
   logic [31:0] value_out, value_out_lp;
   logic        op_done, op_done_lp, op_error, op_error_lp;
   logic [1:0]  coll, coll_lp;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: chained table [index][slot], linear table state 0 empty, 1 valid, 2 tombstone
   logic        cm_v [64][4];
   logic [31:0] cm_k [64][4];
   logic [31:0] cm_d [64][4];
   int          lm_s [4];
   logic [31:0] lm_k [4];
   logic [31:0] lm_d [4];

   always #5 clk = ~clk;

   hash_table_kv dut (
      .clk(clk), .rst(rst), .key_in(key_in), .value_in(value_in), .op_sel(op_sel),
      .op_en(op_en), .value_out(value_out), .op_done(op_done), .op_error(op_error),
      .collision_count(coll)
   );

   hash_table_kv #(.TOTAL_INDEX(4), .COLLISION_METHOD("LINEAR_PROBING")) dut_lp (
      .clk(clk), .rst(rst_lp), .key_in(key_in), .value_in(value_in), .op_sel(op_sel),
      .op_en(op_en_lp), .value_out(value_out_lp), .op_done(op_done_lp), .op_error(op_error_lp),
      .collision_count(coll_lp)
   );

   task automatic model_clear(input bit lp);
      if (lp) begin
         for (int e = 0; e < 4; e++) lm_s[e] = 0;
      end else begin
         for (int i = 0; i < 64; i++)
            for (int s = 0; s < 4; s++) cm_v[i][s] = 1'b0;
      end
   endtask

   task automatic model_op(input bit lp, input logic [1:0] op, input logic [31:0] k,
                           input logic [31:0] v, output logic [31:0] ev, output logic ee,
                           output logic [1:0] ec);
      int hit, fr, c, idx;
      hit = -1; fr = -1; c = 0; ev = '0; ee = 1'b0;
      idx = lp ? int'(k % 4) : int'(k % 64);
      if (op != OP_R) begin
         if (!lp) begin
            for (int s = 0; s < 4; s++) begin
               if (cm_v[idx][s] && cm_k[idx][s] == k) begin hit = s; break; end
               if (cm_v[idx][s]) c++;
               else if (fr < 0) fr = s;
            end
         end else begin
            for (int p = 0; p < 4; p++) begin
               int e;
               e = (idx + p) % 4;
               if (lm_s[e] == 1 && lm_k[e] == k) begin hit = e; break; end
               if (lm_s[e] == 1) c++;
               else begin
                  if (fr < 0) fr = e;
                  if (lm_s[e] == 0) break;
               end
            end
         end
      end
      if (c > 3) c = 3;
      ec = 2'(c);
      case (op)
         OP_I: begin
            if (hit >= 0) begin
               if (lp) lm_d[hit] = v; else cm_d[idx][hit] = v;
            end else if (fr >= 0) begin
               if (lp) begin lm_s[fr] = 1; lm_k[fr] = k; lm_d[fr] = v; end
               else begin cm_v[idx][fr] = 1'b1; cm_k[idx][fr] = k; cm_d[idx][fr] = v; end
            end else ee = 1'b1;
         end
         OP_D: begin
            if (hit >= 0) begin
               if (lp) lm_s[hit] = 2; else cm_v[idx][hit] = 1'b0;
            end else ee = 1'b1;
         end
         OP_S: begin
            if (hit >= 0) ev = lp ? lm_d[hit] : cm_d[idx][hit];
            else ee = 1'b1;
         end
         default: ee = 1'b1;
      endcase
   endtask

   // Drives one op, scrambles inputs while busy, and reports what the DUT did
   task automatic run_op(input bit lp, input logic [1:0] op, input logic [31:0] k,
                         input logic [31:0] v, output logic r_done, output logic [31:0] r_val,
                         output logic r_err, output logic [1:0] r_coll, output logic r_gone,
                         output logic [31:0] ev, output logic ee, output logic [1:0] ec);
      int n;
      model_op(lp, op, k, v, ev, ee, ec);
      @(negedge clk);
      op_sel = op; key_in = k; value_in = v;
      if (lp) op_en_lp = 1'b1; else op_en = 1'b1;
      @(negedge clk);
      op_en = 1'b0; op_en_lp = 1'b0;
      r_done = 1'b0; n = 0;
      while (n < 40) begin
         if (lp ? op_done_lp : op_done) begin r_done = 1'b1; break; end
         key_in = $urandom; value_in = $urandom; op_sel = 2'($urandom);
         @(negedge clk);
         n++;
      end
      r_val  = lp ? value_out_lp : value_out;
      r_err  = lp ? op_error_lp : op_error;
      r_coll = lp ? coll_lp : coll;
      @(negedge clk);
      r_gone = !(lp ? op_done_lp : op_done);
   endtask

   task automatic test_reset;
      vectors++;
      if ({value_out, op_done, op_error, coll} !== 35'd0) begin
         miscompares++;
         $display("FAIL reset_chain: got val=%0h done=%0b err=%0b coll=%0d want all 0", value_out, op_done, op_error, coll);
      end
      vectors++;
      if ({value_out_lp, op_done_lp, op_error_lp, coll_lp} !== 35'd0) begin
         miscompares++;
         $display("FAIL reset_lp: got val=%0h done=%0b err=%0b coll=%0d want all 0", value_out_lp, op_done_lp, op_error_lp, coll_lp);
      end
   endtask

   task automatic test_directed(input bit lp, input string name);
      vec_t tbl [$];
      logic dn, er, gone, ee; logic [31:0] vl, ev; logic [1:0] cl, ec;
      if (!lp) begin
         tbl.push_back({OP_I, 32'd5,   32'd100, 32'd0,   1'b0, 2'd0});
         tbl.push_back({OP_S, 32'd5,   32'd0,   32'd100, 1'b0, 2'd0});
         tbl.push_back({OP_I, 32'd1,   32'd10,  32'd0,   1'b0, 2'd0});
         tbl.push_back({OP_I, 32'd65,  32'd11,  32'd0,   1'b0, 2'd1});
         tbl.push_back({OP_I, 32'd129, 32'd12,  32'd0,   1'b0, 2'd2});
         tbl.push_back({OP_I, 32'd193, 32'd13,  32'd0,   1'b0, 2'd3});
         tbl.push_back({OP_S, 32'd193, 32'd0,   32'd13,  1'b0, 2'd3});
         tbl.push_back({OP_I, 32'd257, 32'd99,  32'd0,   1'b1, 2'd3});
         tbl.push_back({OP_S, 32'd257, 32'd0,   32'd0,   1'b1, 2'd3});
         tbl.push_back({OP_D, 32'd65,  32'd0,   32'd0,   1'b0, 2'd1});
         tbl.push_back({OP_S, 32'd65,  32'd0,   32'd0,   1'b1, 2'd3});
         tbl.push_back({OP_S, 32'd129, 32'd0,   32'd12,  1'b0, 2'd1});
         tbl.push_back({OP_I, 32'd257, 32'd14,  32'd0,   1'b0, 2'd3});
         tbl.push_back({OP_S, 32'd257, 32'd0,   32'd14,  1'b0, 2'd1});
         tbl.push_back({OP_D, 32'd7,   32'd0,   32'd0,   1'b1, 2'd0});
         tbl.push_back({OP_I, 32'd5,   32'd200, 32'd0,   1'b0, 2'd0});
         tbl.push_back({OP_S, 32'd5,   32'd0,   32'd200, 1'b0, 2'd0});
         tbl.push_back({OP_R, 32'd5,   32'd77,  32'd0,   1'b1, 2'd0});
         tbl.push_back({OP_S, 32'd5,   32'd0,   32'd200, 1'b0, 2'd0});
      end else begin
         tbl.push_back({OP_I, 32'd0,  32'd50, 32'd0,  1'b0, 2'd0});
         tbl.push_back({OP_I, 32'd4,  32'd51, 32'd0,  1'b0, 2'd1});
         tbl.push_back({OP_I, 32'd8,  32'd52, 32'd0,  1'b0, 2'd2});
         tbl.push_back({OP_S, 32'd8,  32'd0,  32'd52, 1'b0, 2'd2});
         tbl.push_back({OP_D, 32'd4,  32'd0,  32'd0,  1'b0, 2'd1});
         tbl.push_back({OP_S, 32'd8,  32'd0,  32'd52, 1'b0, 2'd1});
         tbl.push_back({OP_I, 32'd12, 32'd53, 32'd0,  1'b0, 2'd2});
         tbl.push_back({OP_S, 32'd12, 32'd0,  32'd53, 1'b0, 2'd1});
         tbl.push_back({OP_I, 32'd3,  32'd54, 32'd0,  1'b0, 2'd0});
         tbl.push_back({OP_I, 32'd7,  32'd55, 32'd0,  1'b1, 2'd3});
         tbl.push_back({OP_S, 32'd7,  32'd0,  32'd0,  1'b1, 2'd3});
         tbl.push_back({OP_S, 32'd3,  32'd0,  32'd54, 1'b0, 2'd0});
         tbl.push_back({OP_D, 32'd99, 32'd0,  32'd0,  1'b1, 2'd3});
      end
      foreach (tbl[i]) begin
         run_op(lp, tbl[i].op, tbl[i].k, tbl[i].v, dn, vl, er, cl, gone, ev, ee, ec);
         vectors++;
         if (dn !== 1'b1 || gone !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done[%0d]: got done=%0b single_pulse=%0b want 1/1", name, i, dn, gone);
         end
         vectors++;
         if (er !== tbl[i].ee || cl !== tbl[i].ec) begin
            miscompares++;
            $display("FAIL %s err/coll[%0d]: got %0b/%0d want %0b/%0d", name, i, er, cl, tbl[i].ee, tbl[i].ec);
         end
         if (tbl[i].op == OP_S) begin
            vectors++;
            if (vl !== tbl[i].ev) begin
               miscompares++;
               $display("FAIL %s value[%0d]: got %0d want %0d", name, i, vl, tbl[i].ev);
            end
         end
      end
   endtask

   task automatic test_random(input bit lp, input int count, input string name);
      logic dn, er, gone, ee; logic [31:0] vl, ev, k; logic [1:0] cl, ec, op; int r;
      for (int i = 0; i < count; i++) begin
         r  = $urandom_range(0, 9);
         op = (r < 4) ? OP_I : (r < 6) ? OP_D : (r < 9) ? OP_S : OP_R;
         k  = lp ? 32'($urandom_range(0, 11))
                 : ((32'($urandom_range(0, 5)) << 6) | 32'($urandom_range(0, 2)));
         run_op(lp, op, k, $urandom, dn, vl, er, cl, gone, ev, ee, ec);
         vectors++;
         if (dn !== 1'b1 || gone !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done[%0d]: got done=%0b single_pulse=%0b want 1/1", name, i, dn, gone);
         end
         vectors++;
         if (er !== ee || cl !== ec || (op == OP_S && vl !== ev)) begin
            miscompares++;
            $display("FAIL %s result[%0d] op=%0d key=%0d: got err=%0b coll=%0d val=%0h want err=%0b coll=%0d val=%0h",
                     name, i, op, k, er, cl, vl, ee, ec, ev);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic ee1, ee2; logic [31:0] ev1, ev2, k, v; logic [1:0] ec1, ec2; int n; logic seen;
      k = (32'($urandom_range(0, 5)) << 6) | 32'd2;
      v = $urandom;
      model_op(1'b0, OP_I, k, v, ev1, ee1, ec1);
      model_op(1'b0, OP_S, k, 32'd0, ev2, ee2, ec2);
      @(negedge clk);
      op_sel = OP_I; key_in = k; value_in = v; op_en = 1'b1;
      seen = 1'b0; n = 0;
      while (n < 40 && !seen) begin @(negedge clk); n++; seen = op_done; end
      vectors++;
      if (seen !== 1'b1 || op_error !== ee1) begin
         miscompares++;
         $display("FAIL b2b_first: got done=%0b err=%0b want 1/%0b", seen, op_error, ee1);
      end
      op_sel = OP_S;
      @(negedge clk);
      op_en = 1'b0;
      seen = 1'b0; n = 0;
      while (n < 40 && !seen) begin seen = op_done; if (!seen) begin @(negedge clk); n++; end end
      vectors++;
      if (seen !== 1'b1 || op_error !== ee2 || value_out !== ev2 || coll !== ec2) begin
         miscompares++;
         $display("FAIL b2b_second: got done=%0b err=%0b val=%0h coll=%0d want 1/%0b/%0h/%0d",
                  seen, op_error, value_out, coll, ee2, ev2, ec2);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op;
      logic dn, er, gone, ee, saw; logic [31:0] vl, ev; logic [1:0] cl, ec;
      @(negedge clk);
      op_sel = OP_S; key_in = 32'd193; op_en = 1'b1;
      @(negedge clk);
      op_en = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      vectors++;
      if ({value_out, op_done, op_error, coll} !== 35'd0) begin
         miscompares++;
         $display("FAIL reset_mid_op: got val=%0h done=%0b err=%0b coll=%0d want all 0", value_out, op_done, op_error, coll);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      saw = 1'b0;
      repeat (8) begin @(negedge clk); if (op_done) saw = 1'b1; end
      vectors++;
      if (saw !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_no_done: got op_done=%0b want 0", saw);
      end
      model_clear(1'b0);
      run_op(1'b0, OP_S, 32'd5, 32'd0, dn, vl, er, cl, gone, ev, ee, ec);
      vectors++;
      if (dn !== 1'b1 || er !== 1'b1 || vl !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_cleared_5: got done=%0b err=%0b val=%0h want 1/1/0", dn, er, vl);
      end
      run_op(1'b0, OP_S, 32'd1, 32'd0, dn, vl, er, cl, gone, ev, ee, ec);
      vectors++;
      if (dn !== 1'b1 || er !== 1'b1 || cl !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_cleared_1: got done=%0b err=%0b coll=%0d want 1/1/0", dn, er, cl);
      end
   endtask

   initial begin
      rst = 1'b0; rst_lp = 1'b0; op_en = 1'b0; op_en_lp = 1'b0;
      key_in = '0; value_in = '0; op_sel = '0;
      model_clear(1'b0);
      model_clear(1'b1);
      repeat (3) @(negedge clk);
      test_reset;
      rst = 1'b1; rst_lp = 1'b1;
      @(negedge clk);
      test_reset;
      test_directed(1'b0, "chain_dir");
      test_directed(1'b1, "lp_dir");
      test_random(1'b0, 80, "chain_rand");
      test_random(1'b1, 60, "lp_rand");
      test_back_to_back;
      test_reset_mid_op;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
